kissp_ctrl: RTL and testbench

KISSP_CTRL -- requirements
Module: kissp_ctrl

---
 rtl/kissp_ctrl.sv | 158 +++++++++++++++
 tb/tb_kissp_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/kissp_ctrl.sv
// kissp_ctrl: multi-cycle control unit for a small load/store core.
// Sequences FETCH/DECODE/EXEC/MEM against a req/ack memory and drives the datapath strobes.
`timescale 1ns/1ps
`default_nettype none

module kissp_ctrl #(
  parameter logic [31:0] PC_RESET    = 32'd0,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic [31:0] alu_out,
  output logic        r_w,
  output logic        r_src,
  output logic        op,
  output logic [4:0]  dst,
  output logic [4:0]  src1,
  output logic [4:0]  src2,
  output logic [4:0]  imm,
  output logic [31:0] pc,
  output logic        halted,
  output logic        error
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_HALT   = 3'd4,
    S_ERROR  = 3'd5
  } state_t;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_LD   = 3'b010;
  localparam logic [2:0] OP_ST   = 3'b011;
  localparam logic [2:0] OP_HALT = 3'b111;
  localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

  state_t      state, state_nx;
  logic [31:0] pc_nx;
  logic [31:9] insn, insn_nx;
  logic [31:0] addr, addr_nx;
  logic [7:0]  cnt, cnt_nx;
  logic        live;
  logic [2:0]  opc;
  logic        unused_rdata;

  // Low instruction bits carry no meaning and are never stored.
  assign unused_rdata = ^mem_rdata[8:0];

  assign opc    = insn[31:29];
  assign dst    = insn[28:24];
  assign src1   = insn[23:19];
  assign src2   = insn[18:14];
  assign imm    = insn[13:9];
  assign op     = (opc != OP_SUB);
  assign halted = (state == S_HALT) || (state == S_ERROR);
  assign error  = (state == S_ERROR);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_FETCH;
      pc    <= PC_RESET;
      insn  <= '0;
      addr  <= '0;
      cnt   <= '0;
      live  <= 1'b0;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      insn  <= insn_nx;
      addr  <= addr_nx;
      cnt   <= cnt_nx;
      live  <= 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    insn_nx  = insn;
    addr_nx  = addr;
    cnt_nx   = cnt;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_addr = pc;
    r_w      = 1'b0;
    r_src    = 1'b1;

    case (state)
      S_FETCH: begin
        // The cycle right after reset stays idle so the request never overlaps reset.
        if (live) begin
          mem_req = 1'b1;
          if (mem_ack) begin
            insn_nx  = mem_rdata[31:9];
            state_nx = S_DECODE;
            cnt_nx   = '0;
          end else if (cnt == TMO_LAST) begin
            state_nx = S_ERROR;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + 8'd1;
          end
        end
      end
      S_DECODE: state_nx = S_EXEC;
      S_EXEC: begin
        case (opc)
          OP_ADD, OP_SUB: begin
            r_w      = 1'b1;
            pc_nx    = pc + 32'd1;
            state_nx = S_FETCH;
          end
          OP_LD, OP_ST: begin
            addr_nx  = alu_out;
            state_nx = S_MEM;
          end
          OP_HALT: state_nx = S_HALT;
          default: begin
            pc_nx    = pc + 32'd1;
            state_nx = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        mem_req  = 1'b1;
        mem_addr = addr;
        mem_we   = (opc == OP_ST);
        if (mem_ack) begin
          if (opc == OP_LD) begin
            r_w   = 1'b1;
            r_src = 1'b0;
          end
          pc_nx    = pc + 32'd1;
          state_nx = S_FETCH;
          cnt_nx   = '0;
        end else if (cnt == TMO_LAST) begin
          state_nx = S_ERROR;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_kissp_ctrl.sv
// Directed and randomized instruction streams checked against an instruction-level model.
`timescale 1ns/1ps
`default_nettype none

module tb_kissp_ctrl;
  localparam logic [31:0] PCR = 32'hFFFF_FFFF;
  localparam int          TMO = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] alu_out = '0;
  logic        mem_req, mem_we, r_w, r_src, op, halted, error;
  logic [31:0] mem_addr, pc;
  logic [4:0]  dst, src1, src2, imm;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] m_pc;
  logic [31:0] rnd, ins;
  logic [2:0]  o;

  kissp_ctrl #(.PC_RESET(PCR), .ACK_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .alu_out(alu_out), .r_w(r_w), .r_src(r_src), .op(op), .dst(dst),
    .src1(src1), .src2(src2), .imm(imm), .pc(pc), .halted(halted), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_fields(input logic [31:0] i);
    chk("dst",  32'(dst),  32'(i[28:24]));
    chk("src1", 32'(src1), 32'(i[23:19]));
    chk("src2", 32'(src2), 32'(i[18:14]));
    chk("imm",  32'(imm),  32'(i[13:9]));
    chk("op",   32'(op),   32'(i[31:29] != 3'b001));
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0; mem_ack = 1'($urandom);
    @(negedge clk); #1;
    chk("rst_pc", pc, PCR);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_rw", 32'(r_w), 32'd0);
    chk("rst_rsrc", 32'(r_src), 32'd1);
    chk_fields(32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    rst_n = 1'b1;
    m_pc  = PCR;
  endtask

  task automatic expect_error(input string tag);
    for (int k = 1; k <= TMO; k++) begin
      @(negedge clk); mem_ack = 1'b0; #1;
      chk({tag, "_req"}, 32'(mem_req), 32'd1);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); mem_ack = (k > 0) ? 1'($urandom) : 1'b0; #1;
      chk({tag, "_err"}, 32'(error), 32'd1);
      chk({tag, "_halt"}, 32'(halted), 32'd1);
      chk({tag, "_req0"}, 32'(mem_req), 32'd0);
      chk({tag, "_rw0"}, 32'(r_w), 32'd0);
    end
  endtask

  // fd/md = request cycle on which ack arrives (0 = never); abort = MEM cycle to assert reset in.
  task automatic run_insn(input logic [31:0] i, input int fd, input int md,
                          input logic [31:0] alu, input int abort);
    logic [2:0] opc;
    logic       ld_ack;
    opc = i[31:29];
    if (fd == 0) begin
      expect_error("fetch_tmo");
      do_reset();
      return;
    end
    for (int k = 1; k <= fd; k++) begin
      @(negedge clk);
      mem_ack = (k == fd); mem_rdata = (k == fd) ? i : $urandom; alu_out = $urandom; #1;
      chk("fetch_req", 32'(mem_req), 32'd1);
      chk("fetch_we", 32'(mem_we), 32'd0);
      chk("fetch_addr", mem_addr, m_pc);
      chk("fetch_pc", pc, m_pc);
      chk("fetch_rw", 32'(r_w), 32'd0);
    end
    @(negedge clk); mem_ack = 1'($urandom); mem_rdata = $urandom; alu_out = alu; #1;
    chk("dec_req", 32'(mem_req), 32'd0);
    chk("dec_rw", 32'(r_w), 32'd0);
    chk_fields(i);
    @(negedge clk); mem_ack = 1'($urandom); #1;
    chk("exec_rw", 32'(r_w), 32'(opc == 3'b000 || opc == 3'b001));
    chk("exec_rsrc", 32'(r_src), 32'd1);
    chk("exec_req", 32'(mem_req), 32'd0);
    chk("exec_halt", 32'(halted), 32'd0);
    chk_fields(i);
    if (opc == 3'b111) begin
      for (int k = 0; k < 20; k++) begin
        @(negedge clk); mem_ack = 1'($urandom); #1;
        chk("halt_halted", 32'(halted), 32'd1);
        chk("halt_error", 32'(error), 32'd0);
        chk("halt_req", 32'(mem_req), 32'd0);
        chk("halt_rw", 32'(r_w), 32'd0);
        chk("halt_pc", pc, m_pc);
      end
      return;
    end
    if (opc == 3'b010 || opc == 3'b011) begin
      if (md == 0) begin
        expect_error("mem_tmo");
        do_reset();
        return;
      end
      for (int k = 1; k <= md; k++) begin
        @(negedge clk); alu_out = $urandom; mem_rdata = $urandom;
        if (k == abort) begin
          mem_ack = 1'b0; rst_n = 1'b0; #1;
          chk("abort_req_before", 32'(mem_req), 32'd1);
          @(negedge clk); #1;
          chk("abort_pc", pc, PCR);
          chk("abort_req", 32'(mem_req), 32'd0);
          chk("abort_rw", 32'(r_w), 32'd0);
          chk("abort_halt", 32'(halted), 32'd0);
          rst_n = 1'b1;
          m_pc  = PCR;
          return;
        end
        mem_ack = (k == md); #1;
        ld_ack = (opc == 3'b010) && (k == md);
        chk("mem_req", 32'(mem_req), 32'd1);
        chk("mem_addr", mem_addr, alu);
        chk("mem_we", 32'(mem_we), 32'(opc == 3'b011));
        chk("mem_rw", 32'(r_w), 32'(ld_ack));
        chk("mem_rsrc", 32'(r_src), 32'(!ld_ack));
        chk_fields(i);
      end
    end
    m_pc = m_pc + 32'd1;
  endtask

  initial begin
    do_reset();
    // NOP at 0xFFFFFFFF wraps the pc to 0, then the reference ADD runs at pc 0
    run_insn(32'h8000_0000, 2, 0, 32'd0, 0);
    run_insn(32'h0208_2000, 1, 0, 32'd0, 0);
    run_insn(32'h4310_0000, 1, 3, 32'h0000_0010, 0);
    run_insn(32'h6123_4567, 2, 2, 32'hCAFE_0000, 0);
    run_insn(32'h2AAA_AAAA, 1, 0, 32'd0, 0);
    for (int n = 0; n < 30; n++) begin
      rnd = $urandom;
      o   = 3'($urandom_range(0, 6));
      ins = {o, rnd[28:0]};
      run_insn(ins, int'($urandom_range(1, 4)), int'($urandom_range(1, 4)), $urandom, 0);
    end
    // Ack on the final permitted cycle is accepted, in FETCH and in MEM
    run_insn(32'h0102_0304, TMO, 0, 32'd0, 0);
    run_insn(32'h4000_0000, 1, TMO, 32'h0000_1234, 0);
    run_insn(32'h0000_0000, 0, 0, 32'd0, 0);
    run_insn(32'h6000_0000, 1, 0, 32'h0000_0040, 0);
    run_insn(32'h4500_0000, 1, 6, 32'h0000_0080, 2);
    run_insn(32'hA000_0000, 1, 0, 32'd0, 0);
    run_insn(32'h0300_0000, 3, 0, 32'd0, 0);
    run_insn(32'hE000_0000, 1, 0, 32'd0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
